// File: rtl/clock_period_meter.sv
// Recovers period and high time, in clk_in cycles, of an asynchronous periodic signal.
// Flags lock when two consecutive periods match and timeout when the signal stops toggling.
module clock_period_meter #(
    parameter int unsigned       WIDTH       = 28,
    parameter logic [WIDTH-1:0]  TIMEOUT     = 28'd100_000_000,
    parameter int unsigned       SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_LAST = TIMEOUT - ONE;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_prev_q, s_prev_d;
    logic [0:0]             state_q, state_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       high_cnt_q, high_cnt_d;
    logic [WIDTH-1:0]       period_q, period_d;
    logic [WIDTH-1:0]       high_q, high_d;
    logic                   valid_q, valid_d;
    logic                   locked_q, locked_d;
    logic                   timeout_q, timeout_d;
    logic                   have_meas_q, have_meas_d;

    logic                   s_cur;
    logic                   rise;
    logic [WIDTH-1:0]       cnt_inc;

    assign s_cur   = sync_q[SYNC_STAGES-1];
    assign rise    = s_cur & ~s_prev_q;
    assign cnt_inc = cnt_q + ONE;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latch).
        sync_d      = {sync_q[SYNC_STAGES-2:0], sig_in};
        s_prev_d    = s_cur;
        state_d     = state_q;
        cnt_d       = cnt_q;
        high_cnt_d  = high_cnt_q;
        period_d    = period_q;
        high_d      = high_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        timeout_d   = timeout_q;
        have_meas_d = have_meas_q;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    cnt_d      = '0;
                    high_cnt_d = ONE;
                    state_d    = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    // The rise cycle itself is the first cycle of the next period and its first high cycle.
                    period_d    = cnt_inc;
                    high_d      = high_cnt_q;
                    valid_d     = 1'b1;
                    cnt_d       = '0;
                    high_cnt_d  = ONE;
                    timeout_d   = 1'b0;
                    locked_d    = have_meas_q && (cnt_inc == period_q);
                    have_meas_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d   = 1'b1;
                    locked_d    = 1'b0;
                    have_meas_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (s_cur) begin
                        high_cnt_d = high_cnt_q + ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (!reset_n) begin
            // Synchronizer resets high so a signal already high at reset release is not a rise.
            sync_q      <= '1;
            s_prev_q    <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            high_cnt_q  <= '0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
            have_meas_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            s_prev_q    <= s_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            high_cnt_q  <= high_cnt_d;
            period_q    <= period_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
            have_meas_q <= have_meas_d;
        end
    end

    assign period_out = period_q;
    assign high_out   = high_q;
    assign meas_valid = valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench for clock_period_meter: waveform table plus scoreboard of expected measurements,
// with hand-written sequences for reset-while-high, timeout/restart and mid-period reset.
module tb_clock_period_meter;

    localparam int WIDTH = 28;
    localparam int SYNC  = 2;
    localparam int TMO   = 50;

    logic             clk_in  = 1'b0;
    logic             reset_n = 1'b0;
    logic             sig_in  = 1'b1;
    logic [WIDTH-1:0] period_out;
    logic [WIDTH-1:0] high_out;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    typedef struct {
        int period;
        int high;
        bit locked;
        int cyc;
    } exp_t;

    typedef struct {
        int h;
        int l;
        int reps;
        int exp_period;
        int exp_high;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    bit   pend_valid = 1'b0;
    int   pend_p     = 0;
    int   pend_h     = 0;
    bit   have_prev  = 1'b0;
    int   prev_p     = 0;
    int   last_rise  = 0;

    clock_period_meter #(
        .WIDTH      (WIDTH),
        .TIMEOUT    (28'd50),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .sig_in    (sig_in),
        .period_out(period_out),
        .high_out  (high_out),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive a rise on sig_in; the rise closes the previously driven segment, whose result is queued.
    task automatic do_rise(input int exp_p, input int exp_h);
        exp_t e;
        if (pend_valid) begin
            e.period  = pend_p;
            e.high    = pend_h;
            e.locked  = have_prev && (pend_p == prev_p);
            e.cyc     = cyc + SYNC + 1;
            sb.push_back(e);
            have_prev = 1'b1;
            prev_p    = pend_p;
        end
        pend_valid = 1'b1;
        pend_p     = exp_p;
        pend_h     = exp_h;
        last_rise  = cyc;
        sig_in     = 1'b1;
    endtask

    task automatic drive_wave(input int h, input int l, input int reps, input int exp_p, input int exp_h);
        for (int r = 0; r < reps; r++) begin
            do_rise(exp_p, exp_h);
            repeat (h) @(negedge clk_in);
            sig_in = 1'b0;
            repeat (l) @(negedge clk_in);
        end
    endtask

    task automatic model_reset();
        pend_valid = 1'b0;
        have_prev  = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period_out"}, period_out, 0);
        check({tag, "_high_out"}, high_out, 0);
        check({tag, "_meas_valid"}, meas_valid, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    // Scoreboard monitor: outputs sampled on the falling edge.
    always @(negedge clk_in) begin
        if (meas_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_meas_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("valid_cycle", cyc, mon_e.cyc);
                check("period_out", period_out, mon_e.period);
                check("high_out", high_out, mon_e.high);
                check("locked", locked, mon_e.locked);
                check("timeout_at_valid", timeout, 0);
            end
        end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
            check("meas_valid_missing", 0, 1);
            mon_e = sb.pop_front();
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[3];
        int   tgt;
        vecs[0] = '{h: 5, l: 5, reps: 4, exp_period: 10, exp_high: 5};
        vecs[1] = '{h: 3, l: 4, reps: 3, exp_period: 7,  exp_high: 3};
        vecs[2] = '{h: 1, l: 1, reps: 6, exp_period: 2,  exp_high: 1};

        // Reset with sig_in already high, held high after release: no false rise.
        repeat (3) @(negedge clk_in);
        check_zero("reset");
        reset_n = 1'b1;
        repeat (6) @(negedge clk_in);
        check("held_high_no_valid", meas_valid, 0);
        sig_in = 1'b0;
        repeat (4) @(negedge clk_in);
        drive_wave(4, 4, 4, 8, 4);

        // Table-driven waveforms: period 10, period 7, minimum period 2.
        for (int i = 0; i < 3; i++) begin
            drive_wave(vecs[i].h, vecs[i].l, vecs[i].reps, vecs[i].exp_period, vecs[i].exp_high);
        end

        // Relock at 10, then stop the signal and wait for the timeout.
        drive_wave(5, 5, 3, 10, 5);
        tgt = last_rise + SYNC + 1 + TMO;
        while (cyc < tgt - 1) @(negedge clk_in);
        check("timeout_before_limit", timeout, 0);
        check("locked_before_limit", locked, 1);
        @(negedge clk_in);
        check("timeout_at_limit", timeout, 1);
        check("locked_at_timeout", locked, 0);
        check("period_hold_at_timeout", period_out, 10);
        check("high_hold_at_timeout", high_out, 5);
        model_reset();
        repeat (5) @(negedge clk_in);
        check("timeout_sticky", timeout, 1);
        drive_wave(5, 5, 1, 10, 5);
        check("timeout_after_first_rise", timeout, 1);
        drive_wave(5, 5, 2, 10, 5);
        check("timeout_cleared", timeout, 0);

        // One-cycle reset in the middle of a locked period.
        do_rise(10, 5);
        repeat (5) @(negedge clk_in);
        sig_in = 1'b0;
        repeat (2) @(negedge clk_in);
        check("locked_before_reset", locked, 1);
        check("scoreboard_drained_before_reset", sb.size(), 0);
        reset_n = 1'b0;
        @(negedge clk_in);
        check_zero("mid_reset");
        reset_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk_in);
        drive_wave(5, 5, 3, 10, 5);

        repeat (6) @(negedge clk_in);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
- Measures a single-bit periodic signal against the board clock. This is the receiving end of the clock divider: the divider turns a divisor into a waveform; this block recovers period and high time, in clk_in cycles, from that waveform.
- Used for self-checking the CPU clock tree and for on-board display of the active CPU clock rate.
- Reports lock when consecutive periods match, and reports timeout when the signal stops.

Parameters:
- WIDTH, 28, width of the period and high-time counters and outputs.
- TIMEOUT, 28'd100_000_000, clk_in cycles without a rising edge before the measurement is abandoned; must be ≥ 2 and ≤ 2^WIDTH-1.
- SYNC_STAGES, 2, number of synchronizer flops on sig_in; must be ≥ 2.

Ports:
- clk_in  input  1  board clock; the only clock.
- reset_n  input  1  synchronous active-low reset, sampled on posedge clk_in.
- sig_in  input  1  measured signal; treated as asynchronous.
- period_out  output  WIDTH  last measured period, in clk_in cycles.
- high_out  output  WIDTH  last measured high time, in clk_in cycles.
- meas_valid  output  1  one-cycle pulse when period_out/high_out update.
- locked  output  1  high while the last two periods are equal.
- timeout  output  1  high after TIMEOUT cycles with no edge (sticky).

Behaviour:
- Reset (reset_n=0 at a clk_in edge) gives:
  - period_out=0, high_out=0, meas_valid=0, locked=0, timeout=0.
  - State IDLE; counters 0.
  - All synchronizer flops and the edge-detect flop = 1, so an input already high at reset never produces a false rising edge.
- Reset applied mid-measurement discards the measurement immediately; no meas_valid is issued.
- Synchronizer: SYNC_STAGES flops, then one edge-detect flop.
  - s_cur is the last sync stage; s_prev is the edge-detect flop.
  - rise = s_cur & ~s_prev.
  - Detection latency from sig_in is fixed at SYNC_STAGES+1 cycles, so it does not bias the period.
- State IDLE:
  - Ignore levels.
  - On rise: cnt<=0, high_cnt<=1, go to MEASURE.
  - No outputs change.
- State MEASURE, cycle with rise:
  - period_out<=cnt+1, high_out<=high_cnt, meas_valid<=1.
  - Then cnt<=0, high_cnt<=1.
  - timeout<=0.
  - locked<=1 if cnt+1 equals the previous period_out and a previous valid measurement exists since the last reset/timeout; otherwise locked<=0.
- State MEASURE, cycle without rise:
  - cnt<=cnt+1.
  - high_cnt<=high_cnt+1 if s_cur=1.
  - high_cnt never exceeds cnt+1.
- Timeout: in MEASURE with no rise and cnt==TIMEOUT-1:
  - timeout<=1, locked<=0, go to IDLE.
  - period_out and high_out hold their last values; no meas_valid.
  - timeout stays 1 until the next meas_valid.
- meas_valid is high for exactly one cycle per measurement. It is never high on consecutive cycles, because the minimum measurable period is 2.
- Arithmetic: all values are unsigned WIDTH bits. cnt cannot exceed TIMEOUT-1, so cnt+1 never wraps.
- Square wave of period P (P ≥ 2) with H high cycles, 1 ≤ H ≤ P-1:
  - First meas_valid occurs SYNC_STAGES+1 cycles after the 2nd sig_in rise.
  - Reports period_out=P, high_out=H.
- Rise coinciding with the timeout cycle: rise wins; the measurement completes and no timeout is raised.
- Glitches narrower than one clk_in cycle may be missed; this is not an error.

Test Plan:
1. sig_in from the divider with DIVISOR=10 (5 high / 5 low) -> 1st meas_valid gives period_out=10, high_out=5, locked=0; 2nd meas_valid gives locked=1; exactly one valid pulse every 10 cycles thereafter.
2. Switch sig_in to period 7, high 3 -> next valid gives period_out=7, high_out=3, locked=0; the following valid gives locked=1.
3. TIMEOUT=50, sig_in stuck low after lock -> timeout=1 and locked=0 exactly 50 cycles after the last detected rise; period_out holds 10; after restart, timeout clears on the first new meas_valid (2nd rise).
4. sig_in held high through reset release, then low 4 / high 4 -> no meas_valid before two true rises; first valid gives period_out=8, high_out=4.
5. Assert reset_n=0 for 1 cycle midway through a period while locked -> all outputs 0 next cycle; no meas_valid until two further rises.
6. Minimum period, sig_in toggling 1-high/1-low -> period_out=2, high_out=1, meas_valid every 2nd cycle, locked=1 from the 2nd measurement.
